// File: rtl/traffic_pkg.sv
// Shared definitions for the traffic light safety monitor: light codes,
// fault cause codes, monitor states and code-legality helpers.
package traffic_pkg;

  localparam logic [2:0] LT_RED = 3'b100;
  localparam logic [2:0] LT_YEL = 3'b010;
  localparam logic [2:0] LT_GRN = 3'b001;
  localparam logic [2:0] LT_OFF = 3'b000;

  localparam logic [2:0] FLT_NONE     = 3'd0;
  localparam logic [2:0] FLT_ENC      = 3'd1;
  localparam logic [2:0] FLT_CONFLICT = 3'd2;
  localparam logic [2:0] FLT_SEQ      = 3'd3;
  localparam logic [2:0] FLT_SHORT    = 3'd4;
  localparam logic [2:0] FLT_STUCK    = 3'd5;

  typedef enum logic [1:0] {
    STARTUP = 2'd0,
    MON     = 2'd1,
    FAULT   = 2'd2
  } mon_state_t;

  function automatic logic code_valid(input logic [2:0] c);
    return (c == LT_RED) || (c == LT_YEL) || (c == LT_GRN);
  endfunction

  // Hold or one forward step around the R->G->Y->R ring.
  function automatic logic step_legal(input logic [2:0] p, input logic [2:0] c);
    return (p == c) ||
           ((p == LT_RED) && (c == LT_GRN)) ||
           ((p == LT_GRN) && (c == LT_YEL)) ||
           ((p == LT_YEL) && (c == LT_RED));
  endfunction

endpackage

// File: rtl/traffic_approach_checker.sv
// Per-approach checker: tracks previous code, colour dwell and whether the
// current phase was entered under monitoring; flags local violations.
module traffic_approach_checker
  import traffic_pkg::*;
#(
  parameter int MIN_GREEN  = 8,
  parameter int MIN_YELLOW = 4,
  parameter int MAX_STUCK  = 16,
  parameter int CNT_W      = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       track,
  input  logic       clr_entered,
  input  logic       mon_en,
  input  logic [2:0] light,
  output logic       enc_err,
  output logic       seq_err,
  output logic       short_err,
  output logic       not_red,
  output logic       changed
);

  localparam logic [CNT_W-1:0] MIN_G_C = CNT_W'(MIN_GREEN);
  localparam logic [CNT_W-1:0] MIN_Y_C = CNT_W'(MIN_YELLOW);
  localparam logic [CNT_W-1:0] MAX_C   = CNT_W'(MAX_STUCK);

  logic [2:0]       prev_q, prev_d;
  logic [CNT_W-1:0] dwell_q, dwell_d;
  logic             entered_q, entered_d;

  assign changed   = (light != prev_q);
  assign enc_err   = !code_valid(light);
  assign not_red   = (light != LT_RED);
  assign seq_err   = code_valid(light) && code_valid(prev_q) && !step_legal(prev_q, light);
  // Dwell is only trusted when the phase start was seen while monitoring.
  assign short_err = entered_q && changed &&
                     (((prev_q == LT_GRN) && (dwell_q < MIN_G_C)) ||
                      ((prev_q == LT_YEL) && (dwell_q < MIN_Y_C)));

  always_comb begin
    prev_d    = prev_q;
    dwell_d   = dwell_q;
    entered_d = entered_q;
    if (track) begin
      prev_d = light;
      if (changed) begin
        dwell_d = CNT_W'(1);
      end else if (dwell_q != MAX_C) begin
        dwell_d = dwell_q + 1'b1;
      end
    end
    if (clr_entered) begin
      entered_d = 1'b0;
    end else if (mon_en) begin
      if (((prev_q == LT_RED) && (light == LT_GRN)) ||
          ((prev_q == LT_GRN) && (light == LT_YEL))) begin
        entered_d = 1'b1;
      end else if ((prev_q == LT_YEL) && (light == LT_RED)) begin
        entered_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_q    <= LT_RED;
      dwell_q   <= '0;
      entered_q <= 1'b0;
    end else begin
      prev_q    <= prev_d;
      dwell_q   <= dwell_d;
      entered_q <= entered_d;
    end
  end

endmodule

// File: rtl/traffic_conflict_monitor.sv
// Safety monitor behind the four-way light controller: validates the light
// codes every cycle, drives the lamps and falls back to flashing red on fault.
module traffic_conflict_monitor
  import traffic_pkg::*;
#(
  parameter int MIN_GREEN   = 8,
  parameter int MIN_YELLOW  = 4,
  parameter int MAX_STUCK   = 16,
  parameter int FLASH_HALF  = 4,
  parameter int STARTUP_CYC = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] n_light,
  input  logic [2:0] s_light,
  input  logic [2:0] e_light,
  input  logic [2:0] w_light,
  input  logic       clear_fault,
  output logic [2:0] n_lamp,
  output logic [2:0] s_lamp,
  output logic [2:0] e_lamp,
  output logic [2:0] w_lamp,
  output logic       fault,
  output logic [2:0] fault_code,
  output logic       mon_active
);

  localparam int CNT_W = $clog2(MAX_STUCK + 1);
  localparam int FL_W  = (FLASH_HALF > 1) ? $clog2(FLASH_HALF) : 1;
  localparam int ST_W  = (STARTUP_CYC > 1) ? $clog2(STARTUP_CYC) : 1;

  localparam logic [CNT_W-1:0] STUCK_LIM = CNT_W'(MAX_STUCK);
  localparam logic [FL_W-1:0]  FL_LAST   = FL_W'(FLASH_HALF - 1);
  localparam logic [ST_W-1:0]  ST_LAST   = ST_W'(STARTUP_CYC - 1);

  logic [3:0][2:0] light_in;
  logic [3:0]      enc_v, seq_v, short_v, not_red_v, changed_v;
  logic            track, clr_entered, mon_en;

  mon_state_t       state_q, state_d;
  logic [ST_W-1:0]  st_cnt_q, st_cnt_d;
  logic [CNT_W-1:0] stuck_q, stuck_d, stuck_inc;
  logic [FL_W-1:0]  flash_q, flash_d;
  logic             flash_off_q, flash_off_d;
  logic [3:0][2:0]  lamp_q, lamp_d;
  logic             fault_q, fault_d;
  logic [2:0]       code_q, code_d, detect_code;
  logic             mon_q, mon_d;
  logic             conflict, stuck_hit;

  assign light_in    = {w_light, e_light, s_light, n_light};
  assign track       = (state_q != FAULT);
  assign clr_entered = (state_q == STARTUP);
  assign mon_en      = (state_q == MON);

  for (genvar gi = 0; gi < 4; gi++) begin : g_appr
    traffic_approach_checker #(
      .MIN_GREEN  (MIN_GREEN),
      .MIN_YELLOW (MIN_YELLOW),
      .MAX_STUCK  (MAX_STUCK),
      .CNT_W      (CNT_W)
    ) u_chk (
      .clk         (clk),
      .rst         (rst),
      .track       (track),
      .clr_entered (clr_entered),
      .mon_en      (mon_en),
      .light       (light_in[gi]),
      .enc_err     (enc_v[gi]),
      .seq_err     (seq_v[gi]),
      .short_err   (short_v[gi]),
      .not_red     (not_red_v[gi]),
      .changed     (changed_v[gi])
    );
  end

  // More than one bit set: clearing the lowest set bit leaves something.
  assign conflict  = ((not_red_v & (not_red_v - 4'd1)) != 4'd0);
  assign stuck_inc = (|changed_v) ? '0 : stuck_q + 1'b1;
  assign stuck_hit = (stuck_inc == STUCK_LIM);

  always_comb begin
    if (|enc_v)           detect_code = FLT_ENC;
    else if (conflict)    detect_code = FLT_CONFLICT;
    else if (|seq_v)      detect_code = FLT_SEQ;
    else if (|short_v)    detect_code = FLT_SHORT;
    else if (stuck_hit)   detect_code = FLT_STUCK;
    else                  detect_code = FLT_NONE;
  end

  always_comb begin
    state_d     = state_q;
    st_cnt_d    = st_cnt_q;
    stuck_d     = stuck_q;
    flash_d     = flash_q;
    flash_off_d = flash_off_q;
    lamp_d      = lamp_q;
    fault_d     = fault_q;
    code_d      = code_q;
    case (state_q)
      STARTUP: begin
        lamp_d  = {4{LT_RED}};
        stuck_d = '0;
        if (st_cnt_q == ST_LAST) begin
          state_d  = MON;
          st_cnt_d = '0;
        end else begin
          st_cnt_d = st_cnt_q + 1'b1;
        end
      end
      MON: begin
        if (detect_code != FLT_NONE) begin
          // The offending sample never reaches the lamps.
          state_d     = FAULT;
          fault_d     = 1'b1;
          code_d      = detect_code;
          lamp_d      = {4{LT_RED}};
          flash_d     = '0;
          flash_off_d = 1'b0;
        end else begin
          lamp_d  = light_in;
          stuck_d = stuck_inc;
        end
      end
      FAULT: begin
        if (clear_fault) begin
          state_d  = STARTUP;
          st_cnt_d = '0;
          fault_d  = 1'b0;
          code_d   = FLT_NONE;
          lamp_d   = {4{LT_RED}};
        end else if (flash_q == FL_LAST) begin
          flash_d     = '0;
          flash_off_d = !flash_off_q;
          lamp_d      = flash_off_q ? {4{LT_RED}} : {4{LT_OFF}};
        end else begin
          flash_d = flash_q + 1'b1;
        end
      end
      default: state_d = STARTUP;
    endcase
    mon_d = (state_d == MON);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= STARTUP;
      st_cnt_q    <= '0;
      stuck_q     <= '0;
      flash_q     <= '0;
      flash_off_q <= 1'b0;
      lamp_q      <= {4{LT_RED}};
      fault_q     <= 1'b0;
      code_q      <= FLT_NONE;
      mon_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      st_cnt_q    <= st_cnt_d;
      stuck_q     <= stuck_d;
      flash_q     <= flash_d;
      flash_off_q <= flash_off_d;
      lamp_q      <= lamp_d;
      fault_q     <= fault_d;
      code_q      <= code_d;
      mon_q       <= mon_d;
    end
  end

  assign n_lamp     = lamp_q[0];
  assign s_lamp     = lamp_q[1];
  assign e_lamp     = lamp_q[2];
  assign w_lamp     = lamp_q[3];
  assign fault      = fault_q;
  assign fault_code = code_q;
  assign mon_active = mon_q;

endmodule

// File: tb/tb_traffic_conflict_monitor.sv
// Self-checking bench for traffic_conflict_monitor: a rule-level model checked
// every cycle, directed scenarios with literal expectations, then random traffic.
module tb_traffic_conflict_monitor;

  localparam int MIN_GREEN   = 8;
  localparam int MIN_YELLOW  = 4;
  localparam int MAX_STUCK   = 16;
  localparam int FLASH_HALF  = 4;
  localparam int STARTUP_CYC = 2;

  localparam logic [2:0] R = 3'b100;
  localparam logic [2:0] Y = 3'b010;
  localparam logic [2:0] G = 3'b001;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       clear_fault = 1'b0;
  logic [2:0] n_light = R, s_light = R, e_light = R, w_light = R;
  logic [2:0] n_lamp, s_lamp, e_lamp, w_lamp;
  logic       fault;
  logic [2:0] fault_code;
  logic       mon_active;

  always #5 clk = ~clk;

  traffic_conflict_monitor #(
    .MIN_GREEN   (MIN_GREEN),
    .MIN_YELLOW  (MIN_YELLOW),
    .MAX_STUCK   (MAX_STUCK),
    .FLASH_HALF  (FLASH_HALF),
    .STARTUP_CYC (STARTUP_CYC)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .n_light     (n_light),
    .s_light     (s_light),
    .e_light     (e_light),
    .w_light     (w_light),
    .clear_fault (clear_fault),
    .n_lamp      (n_lamp),
    .s_lamp      (s_lamp),
    .e_lamp      (e_lamp),
    .w_lamp      (w_lamp),
    .fault       (fault),
    .fault_code  (fault_code),
    .mon_active  (mon_active)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [11:0] act, input logic [11:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model (state after the next clock edge) -------
  int         m_state;   // 0 startup, 1 monitoring, 2 fault
  int         m_su, m_stuck, m_age;
  logic [2:0] m_prev [4];
  int         m_dwell [4];
  bit         m_ent [4];
  logic [2:0] x_lamp [4];
  logic       x_fault;
  logic [2:0] x_code;
  logic       x_mon;
  bit         m_valid = 0;

  function automatic bit is_code(input logic [2:0] c);
    return (c == R) || (c == Y) || (c == G);
  endfunction

  function automatic bit ring_ok(input logic [2:0] p, input logic [2:0] c);
    return (p == c) || (p == R && c == G) || (p == G && c == Y) || (p == Y && c == R);
  endfunction

  task automatic model_track(input logic [2:0] l [4]);
    for (int i = 0; i < 4; i++) begin
      if (l[i] != m_prev[i]) m_dwell[i] = 1;
      else if (m_dwell[i] < MAX_STUCK) m_dwell[i]++;
      m_prev[i] = l[i];
    end
  endtask

  task automatic model_step();
    logic [2:0] l [4];
    bit enc, seq, sh, any_chg;
    int nr, code, stuck_next;
    l[0] = n_light; l[1] = s_light; l[2] = e_light; l[3] = w_light;
    if (rst) begin
      m_valid = 1; m_state = 0; m_su = 0; m_stuck = 0; m_age = 0;
      for (int i = 0; i < 4; i++) begin
        m_prev[i] = R; m_dwell[i] = 0; m_ent[i] = 0; x_lamp[i] = R;
      end
      x_fault = 0; x_code = 0; x_mon = 0;
      return;
    end
    if (!m_valid) return;
    case (m_state)
      0: begin
        model_track(l);
        for (int i = 0; i < 4; i++) begin m_ent[i] = 0; x_lamp[i] = R; end
        m_su++;
        if (m_su == STARTUP_CYC) begin
          m_state = 1; x_mon = 1; m_stuck = 0; m_su = 0;
        end
      end
      1: begin
        enc = 0; seq = 0; sh = 0; any_chg = 0; nr = 0;
        for (int i = 0; i < 4; i++) begin
          if (!is_code(l[i])) enc = 1;
          if (l[i] != R) nr++;
          if (l[i] != m_prev[i]) begin
            any_chg = 1;
            if (is_code(l[i]) && is_code(m_prev[i]) && !ring_ok(m_prev[i], l[i])) seq = 1;
            if (m_ent[i] && ((m_prev[i] == G && m_dwell[i] < MIN_GREEN) ||
                             (m_prev[i] == Y && m_dwell[i] < MIN_YELLOW))) sh = 1;
          end
        end
        stuck_next = any_chg ? 0 : m_stuck + 1;
        code = enc ? 1 : (nr > 1) ? 2 : seq ? 3 : sh ? 4 : (stuck_next == MAX_STUCK) ? 5 : 0;
        for (int i = 0; i < 4; i++) begin
          if ((m_prev[i] == R && l[i] == G) || (m_prev[i] == G && l[i] == Y)) m_ent[i] = 1;
          else if (m_prev[i] == Y && l[i] == R) m_ent[i] = 0;
        end
        model_track(l);
        if (code != 0) begin
          m_state = 2; x_fault = 1; x_code = 3'(code); x_mon = 0; m_age = 0;
          for (int i = 0; i < 4; i++) x_lamp[i] = R;
        end else begin
          for (int i = 0; i < 4; i++) x_lamp[i] = l[i];
          m_stuck = stuck_next;
        end
      end
      default: begin
        if (clear_fault) begin
          m_state = 0; x_fault = 0; x_code = 0; m_su = 0;
          for (int i = 0; i < 4; i++) x_lamp[i] = R;
        end else begin
          m_age++;
          for (int i = 0; i < 4; i++) x_lamp[i] = (((m_age / FLASH_HALF) % 2) != 0) ? 3'b000 : R;
        end
      end
    endcase
  endtask

  // Compare on the falling edge, then advance the model with the inputs the
  // next rising edge will sample.
  initial begin
    forever begin
      @(negedge clk);
      if (m_valid) begin
        chk("model_n_lamp", n_lamp, x_lamp[0]);
        chk("model_s_lamp", s_lamp, x_lamp[1]);
        chk("model_e_lamp", e_lamp, x_lamp[2]);
        chk("model_w_lamp", w_lamp, x_lamp[3]);
        chk("model_fault", fault, x_fault);
        chk("model_fault_code", fault_code, x_code);
        chk("model_mon_active", mon_active, x_mon);
      end
      model_step();
    end
  end

  // ---------------- stimulus ---------------------------------------------------
  logic [2:0] lt [4];

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic apply();
    n_light = lt[0]; s_light = lt[1]; e_light = lt[2]; w_light = lt[3];
  endtask

  task automatic all_red();
    for (int i = 0; i < 4; i++) lt[i] = R;
    apply();
  endtask

  task automatic recover();
    all_red();
    clear_fault = 1'b1;
    cyc();
    clear_fault = 1'b0;
    cyc();
    cyc();
  endtask

  function automatic logic [2:0] rand_code();
    int r;
    logic [2:0] c;
    r = $urandom_range(0, 9);
    if (r < 3) c = R;
    else if (r < 6) c = G;
    else if (r < 9) c = Y;
    else c = 3'($urandom_range(0, 7));
    return c;
  endfunction

  initial begin
    int ncyc, glen, ylen;
    all_red();
    rst = 1'b1;
    repeat (3) cyc();
    chk("reset_n_lamp", n_lamp, R);
    chk("reset_w_lamp", w_lamp, R);
    chk("reset_fault", fault, 0);
    chk("reset_code", fault_code, 0);
    chk("reset_mon", mon_active, 0);
    rst = 1'b0;
    cyc();
    chk("mon_cycle2", mon_active, 0);
    cyc();
    chk("mon_cycle3", mon_active, 1);

    // Legal rotation with random but legal hold lengths.
    ncyc = 0;
    while (ncyc < 96) begin
      for (int a = 0; a < 4; a++) begin
        glen = $urandom_range(MIN_GREEN, MIN_GREEN + 3);
        ylen = $urandom_range(MIN_YELLOW, MIN_YELLOW + 2);
        lt[a] = G; apply();
        cyc();
        if (a == 0) chk("pass_n_green", n_lamp, G);
        repeat (glen - 1) cyc();
        lt[a] = Y; apply();
        repeat (ylen) cyc();
        lt[a] = R; apply();
        ncyc += glen + ylen;
      end
      clear_fault = 1'b1;
      cyc();
      clear_fault = 1'b0;
      chk("clear_in_mon_fault", fault, 0);
      chk("clear_in_mon_active", mon_active, 1);
    end
    chk("legal_no_fault", fault, 0);

    // Conflict and flash pattern.
    lt[0] = G; lt[2] = G; apply();
    cyc();
    chk("conflict_fault", fault, 1);
    chk("conflict_code", fault_code, 2);
    chk("conflict_lamp_e", e_lamp, R);
    all_red();
    for (int k = 2; k <= 12; k++) begin
      cyc();
      chk("flash_lamp_n", n_lamp, (k >= 5 && k <= 8) ? 3'b000 : R);
    end
    chk("conflict_code_hold", fault_code, 2);

    // Recovery: two startup cycles of red, then pass-through.
    clear_fault = 1'b1;
    cyc();
    clear_fault = 1'b0;
    chk("clear_fault_low", fault, 0);
    chk("clear_code_zero", fault_code, 0);
    chk("clear_lamp_red1", n_lamp, R);
    cyc();
    chk("clear_lamp_red2", n_lamp, R);
    chk("clear_mon_low", mon_active, 0);
    cyc();
    chk("clear_mon_back", mon_active, 1);
    lt[0] = G; apply();
    cyc();
    chk("resume_pass_n", n_lamp, G);

    // Green straight to red after 8 cycles.
    repeat (MIN_GREEN - 1) cyc();
    lt[0] = R; apply();
    cyc();
    chk("seq_code", fault_code, 3);

    // Observed green held only 5 cycles.
    recover();
    lt[0] = G; apply();
    repeat (5) cyc();
    lt[0] = Y; apply();
    cyc();
    chk("short_code", fault_code, 4);

    // Bad encoding together with a conflict.
    recover();
    lt[0] = 3'b011; lt[2] = G; apply();
    cyc();
    chk("enc_code", fault_code, 1);

    // Frozen inputs.
    recover();
    lt[0] = G; apply();
    for (int i = 1; i <= MAX_STUCK + 1; i++) begin
      cyc();
      if (i == MAX_STUCK) chk("stuck_not_yet", fault, 0);
    end
    chk("stuck_code", fault_code, 5);

    // Reset while flashing dark.
    repeat (4) cyc();
    chk("fault_dark_lamp", n_lamp, 3'b000);
    all_red();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("midfault_rst_lamp", n_lamp, R);
    chk("midfault_rst_fault", fault, 0);
    chk("midfault_rst_code", fault_code, 0);
    repeat (2) cyc();

    // Random traffic against the model.
    for (int i = 0; i < 800; i++) begin
      for (int a = 0; a < 4; a++)
        if ($urandom_range(0, 99) < 15) lt[a] = rand_code();
      apply();
      clear_fault = ($urandom_range(0, 11) == 0);
      rst = ($urandom_range(0, 249) == 0);
      cyc();
    end
    clear_fault = 1'b0;
    rst = 1'b0;
    cyc();
    cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/traffic_conflict_monitor.md
Name: traffic_conflict_monitor

Overview:
Safety stage directly downstream of the four-way traffic light controller. Consumes the n/s/e/w 3-bit light codes, checks them every cycle for encoding, conflict, sequence, dwell and stuck violations, and drives the lamp outputs. Any violation latches a fault and forces all lamps to flashing red until software clears it. Light code: bit2 = red, bit1 = yellow, bit0 = green (100 R, 010 Y, 001 G).

Parameters:
MIN_GREEN, 8, minimum cycles a green must be held before going yellow
MIN_YELLOW, 4, minimum cycles a yellow must be held before going red
MAX_STUCK, 16, maximum cycles all four inputs may stay unchanged
FLASH_HALF, 4, half-period, in cycles, of the fault flash
STARTUP_CYC, 2, cycles spent in STARTUP before monitoring

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
n_light  in  3  north code from controller
s_light  in  3  south code
e_light  in  3  east code
w_light  in  3  west code
clear_fault  in  1  single-cycle pulse; leaves FAULT
n_lamp  out  3  north lamp drive
s_lamp  out  3  south lamp drive
e_lamp  out  3  east lamp drive
w_lamp  out  3  west lamp drive
fault  out  1  high while in FAULT
fault_code  out  3  latched cause; 0 = none
mon_active  out  1  high in MON

Behaviour:
- Reset: all lamps 100; fault 0; fault_code 0; mon_active 0; state STARTUP; flash, stuck and dwell counters 0; all entered flags 0. rst has priority in every state, including mid-FAULT.
- All outputs are registered. Lamps have 1-cycle latency: in MON with no fault this edge, lamp_x(t+1) = x_light(t).
- STARTUP:
  - Lamps held at 100; no checks run.
  - prev_x <= x_light every cycle.
  - After STARTUP_CYC cycles, go to MON with the stuck timer cleared.
- MON: checks on the current sample versus prev_x each cycle. Codes, lowest number wins when several fire together:
  1 ENC: any input not exactly 100, 010 or 001.
  2 CONFLICT: more than one approach not red.
  3 SEQ: any approach makes an illegal transition. Legal: hold, R->G, G->Y, Y->R. Illegal: G->R, Y->G, R->Y.
  4 SHORT: an approach leaves G with dwell < MIN_GREEN, or leaves Y with dwell < MIN_YELLOW. Applies only if that colour's entry was observed in MON (entered flag set). This exempts the first phase after STARTUP.
  5 STUCK: the stuck timer reaches MAX_STUCK.
- Per-approach dwell counter:
  - Resets to 1 on a colour change, otherwise increments, saturating at MAX_STUCK.
  - The entered flag is set on an observed R->G or G->Y transition in MON, and cleared on Y->R.
- Stuck timer: resets to 0 when any input changes, otherwise increments.
- On a detected fault at edge t:
  - state <= FAULT; fault <= 1; fault_code latched.
  - Lamps load 100 at that same edge, so the offending value is never driven to the lamps.
- FAULT:
  - Flash counter runs; all lamps alternate between 100 and 000 every FLASH_HALF cycles, starting with 100.
  - Inputs are ignored; fault_code holds.
  - clear_fault -> STARTUP: fault 0, fault_code 0, lamps 100.
- clear_fault outside FAULT: ignored.
- Counter widths: $clog2(MAX_STUCK+1). Flash counter width: $clog2(FLASH_HALF).

Decomposition:
- Shared package traffic_pkg holds:
  - light code constants LT_RED, LT_YEL, LT_GRN;
  - fault code constants FLT_NONE, FLT_ENC, FLT_CONFLICT, FLT_SEQ, FLT_SHORT, FLT_STUCK;
  - state enum mon_state_t {STARTUP, MON, FAULT}.
- Sub-module traffic_approach_checker, instantiated 4x. It holds prev code, dwell counter and entered flag, and outputs enc_err, seq_err, short_err, not_red and changed.
- The top level does conflict counting, the stuck timer, priority encoding, the FSM, flash and the lamp registers.

Test Plan:
- Legal sequence, no fault: drive G8/Y4 rotating N,S,E,W for 96 cycles after reset. Required: fault stays 0; each lamp equals its input delayed 1 cycle; mon_active = 1 from cycle 3.
- Conflict: in MON, drive n=001 and e=001 together. Required: next cycle fault = 1, fault_code = 2, all lamps 100; lamps read 000 on cycles 5-8 of FAULT and 100 on cycles 9-12.
- Sequence and dwell:
  - N goes G->R directly after 8 cycles -> code 3.
  - Separately, an observed N green held only 5 cycles, then Y -> code 4.
- Simultaneous errors and stuck:
  - n=011 together with e=001 -> code 1 (ENC outranks CONFLICT).
  - All inputs frozen at 001/100/100/100 -> fault_code 5 exactly 16 cycles after the last change.
- Recovery and reset:
  - clear_fault pulse in FAULT -> fault 0, lamps 100 for 2 cycles, then MON with pass-through resumed.
  - rst asserted mid-FAULT -> reset values on the next cycle.
  - clear_fault in MON -> no effect.
